delay_marker_generator: RTL and testbench
=========================================

DELAY_MARKER_GENERATOR -- requirements
Module: delay_marker_generator

Interface
REQ-001 Parameter MAX_OUTSTANDING, default 4, meaning maximum tracked in-flight memory requests (power of two, 2..16).
REQ-002 Parameter LAT_WIDTH, default 8, meaning width of the timestamp counter and latency result.
REQ-003 Parameter TIMEOUT_CYCLES, default 200, meaning age of the oldest request at which timeout is flagged (must be < 2^LAT_WIDTH).
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 req_i  input  1  memory-bus request from core.
REQ-007 gnt_i  input  1  memory-bus grant; request accepted when req_i && gnt_i.
REQ-008 rvalid_i  input  1  memory-bus response valid, one cycle per accepted request, in order.
REQ-009 clear_i  input  1  clears sticky error flags.
REQ-010 marker_o  output  1  one-cycle pulse per tracked accepted request; drives the delay stage's marker input.
REQ-011 feedback_o  output  1  one-cycle pulse per tracked response; drives the delay stage's feedback input.
REQ-012 outstanding_o  output  $clog2(MAX_OUTSTANDING)+1  current in-flight count.
REQ-013 full_o  output  1  high in state FULL.
REQ-014 last_latency_o  output  LAT_WIDTH  latency of most recently completed request.
REQ-015 overflow_o, underflow_o, timeout_o  output  1 each  sticky error flags.

Function
REQ-016 Accept = req_i && gnt_i && outstanding < MAX_OUTSTANDING; accept at MAX_OUTSTANDING is dropped (not counted, no marker) and sets overflow_o.
REQ-017 Retire = rvalid_i && outstanding > 0; rvalid_i at outstanding 0 is ignored and sets underflow_o.
REQ-018 marker_o registered: high exactly in cycle N+1 for an accept in cycle N.
REQ-019 feedback_o registered: high exactly in cycle N+1 for a retire in cycle N.
REQ-020 outstanding: +1 on accept only, -1 on retire only, unchanged on simultaneous accept and retire; outstanding_o registered, updated cycle N+1.
REQ-021 Free-running timestamp counter, LAT_WIDTH bits, increments every cycle, wraps 2^LAT_WIDTH-1 -> 0.
REQ-022 Timestamp FIFO, depth MAX_OUTSTANDING: push current timestamp on accept, pop on retire; simultaneous push and pop allowed at any occupancy including full (pop-then-push semantics, occupancy unchanged).
REQ-023 On retire, last_latency_o <= timestamp_now - popped_timestamp, modulo 2^LAT_WIDTH (correct across wrap); retire one cycle after accept yields 1.
REQ-024 last_latency_o holds value until next retire.
REQ-025 timeout_o sets when outstanding > 0 and (timestamp_now - FIFO head timestamp) mod 2^LAT_WIDTH == TIMEOUT_CYCLES.
REQ-026 FSM states IDLE, BUSY, FULL; state reflects next-cycle outstanding count: 0 -> IDLE, 1..MAX-1 -> BUSY, MAX -> FULL.
REQ-027 Transitions: IDLE->BUSY on accept; BUSY->FULL when count reaches MAX; FULL->BUSY on retire without accept; BUSY->IDLE when count reaches 0; IDLE->FULL only when MAX_OUTSTANDING == 1 (not permitted by REQ-001, so unreachable).
REQ-028 clear_i clears overflow_o, underflow_o, timeout_o next cycle; if a set condition coincides with clear_i, set wins.
REQ-029 Error flags, counters and FIFO never affect req_i/gnt_i/rvalid_i; block is observe-only.

Reset
REQ-030 While rst high at a clock edge: state IDLE, outstanding_o 0, FIFO empty, timestamp 0, marker_o 0, feedback_o 0, full_o 0, last_latency_o 0, all sticky flags 0.
REQ-031 rst mid-operation discards all in-flight tracking; responses arriving after reset release for pre-reset requests count as underflow.
REQ-032 Inputs ignored in any cycle rst is high.

Verification
REQ-033 Single access: accept cycle 10, rvalid cycle 13 -> marker_o cycle 11, feedback_o cycle 14, last_latency_o = 3, outstanding 1 then 0, state IDLE->BUSY->IDLE.
REQ-034 Fill: 4 back-to-back accepts, 5th req/gnt -> outstanding_o 4, full_o 1, no 5th marker, overflow_o 1; clear_i -> overflow_o 0.
REQ-035 Simultaneous accept and retire at outstanding 4 -> outstanding stays 4, one marker and one feedback pulse, latencies in order.
REQ-036 Wrap: LAT_WIDTH 8, accept at timestamp 250, rvalid at timestamp 5 -> last_latency_o = 11.
REQ-037 Spurious rvalid_i at outstanding 0 -> underflow_o 1, no feedback_o; request held 200 cycles without rvalid -> timeout_o 1.
REQ-038 rst asserted with outstanding 3 -> all outputs to reset values next edge; subsequent rvalid_i -> underflow_o 1.

Source files
------------

// File: rtl/delay_marker_generator_if.sv
`default_nettype none
// ============================================================================
// Module      : delay_marker_generator_if
// Description : Memory-bus handshake observed by the delay marker generator.
//               The bus side drives the signals (master); the generator only
//               observes them (slave).
// Revision    : 1.0  initial release
// ============================================================================
interface delay_marker_generator_if;
   logic req;
   logic gnt;
   logic rvalid;

   modport master (output req, gnt, rvalid);
   modport slave  (input  req, gnt, rvalid);
endinterface
`default_nettype wire

// File: rtl/delay_marker_generator.sv
`default_nettype none
// ============================================================================
// Module      : delay_marker_generator
// Description : Observes a memory bus, tracks in-flight requests with a
//               timestamp FIFO, emits marker/feedback pulses for a delay stage
//               and reports request latency plus sticky error flags.
// Revision    : 1.0  initial release
// ============================================================================
module delay_marker_generator #(
   parameter int MAX_OUTSTANDING = 4,
   parameter int LAT_WIDTH       = 8,
   parameter int TIMEOUT_CYCLES  = 200
) (
   input  wire logic                               clk,
   input  wire logic                               rst,
   delay_marker_generator_if.slave                 bus_i,
   input  wire logic                               clear_i,
   output logic                                    marker_o,
   output logic                                    feedback_o,
   output logic [$clog2(MAX_OUTSTANDING):0]        outstanding_o,
   output logic                                    full_o,
   output logic [LAT_WIDTH-1:0]                    last_latency_o,
   output logic                                    overflow_o,
   output logic                                    underflow_o,
   output logic                                    timeout_o
);

   localparam int                 CNT_W     = $clog2(MAX_OUTSTANDING) + 1;
   localparam int                 PTR_W     = $clog2(MAX_OUTSTANDING);
   localparam logic [CNT_W-1:0]   C_MAX_CNT = CNT_W'(MAX_OUTSTANDING);
   localparam logic [LAT_WIDTH-1:0] C_TIMEOUT = LAT_WIDTH'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_FULL = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [LAT_WIDTH-1:0]   ts_q;
   logic [LAT_WIDTH-1:0]   mem_q [MAX_OUTSTANDING];
   logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
   logic                   marker_q, feedback_q;
   logic [LAT_WIDTH-1:0]   last_lat_q;
   logic                   ovf_q, unf_q, tmo_q;

   logic                   w_accept, w_retire;
   logic                   w_ovf_set, w_unf_set, w_tmo_set;
   logic [LAT_WIDTH-1:0]   w_head_age;

   // A retire frees a slot in the same cycle, so a request arriving while full
   // is still taken when a response retires alongside it (pop-then-push).
   assign w_retire   = bus_i.rvalid && (cnt_q != '0);
   assign w_accept   = bus_i.req && bus_i.gnt && ((cnt_q < C_MAX_CNT) || w_retire);
   assign w_head_age = ts_q - mem_q[rd_ptr_q];
   assign w_ovf_set  = bus_i.req && bus_i.gnt && !w_accept;
   assign w_unf_set  = bus_i.rvalid && (cnt_q == '0);
   assign w_tmo_set  = (cnt_q != '0) && (w_head_age == C_TIMEOUT);

   // Next in-flight count and FSM state derived from that count.
   always_comb begin
      cnt_d   = cnt_q;
      state_d = state_q;
      case ({w_accept, w_retire})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
      case (state_q)
         ST_IDLE: if (w_accept) state_d = (cnt_d == C_MAX_CNT) ? ST_FULL : ST_BUSY;
         ST_BUSY: begin
            if (cnt_d == C_MAX_CNT)  state_d = ST_FULL;
            else if (cnt_d == '0)    state_d = ST_IDLE;
         end
         ST_FULL: if (w_retire && !w_accept) state_d = ST_BUSY;
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Timestamp storage; contents are only meaningful between the pointers.
   always_ff @(posedge clk) begin
      if (!rst && w_accept) mem_q[wr_ptr_q] <= ts_q;
   end

   // Counters, pointers, pulses, latency result and sticky flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         ts_q       <= '0;
         cnt_q      <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         marker_q   <= 1'b0;
         feedback_q <= 1'b0;
         last_lat_q <= '0;
         ovf_q      <= 1'b0;
         unf_q      <= 1'b0;
         tmo_q      <= 1'b0;
      end else begin
         ts_q       <= ts_q + 1'b1;
         cnt_q      <= cnt_d;
         marker_q   <= w_accept;
         feedback_q <= w_retire;
         if (w_accept) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (w_retire) begin
            rd_ptr_q   <= rd_ptr_q + 1'b1;
            last_lat_q <= w_head_age;
         end
         // A set condition in the same cycle as clear_i wins.
         ovf_q <= (ovf_q && !clear_i) || w_ovf_set;
         unf_q <= (unf_q && !clear_i) || w_unf_set;
         tmo_q <= (tmo_q && !clear_i) || w_tmo_set;
      end
   end

   assign marker_o       = marker_q;
   assign feedback_o     = feedback_q;
   assign outstanding_o  = cnt_q;
   assign full_o         = (state_q == ST_FULL);
   assign last_latency_o = last_lat_q;
   assign overflow_o     = ovf_q;
   assign underflow_o    = unf_q;
   assign timeout_o      = tmo_q;

endmodule
`default_nettype wire

// File: tb/tb_delay_marker_generator.sv
`default_nettype none
// ============================================================================
// Module      : tb_delay_marker_generator
// Description : Self-checking bench for delay_marker_generator with a
//               reference model and a latency scoreboard.
// Revision    : 1.0  initial release
// ============================================================================
module tb_delay_marker_generator;

   localparam int MAXO    = 4;
   localparam int TIMEOUT = 200;

   logic       clk = 1'b0;
   logic       rst;
   logic       clear_i;
   logic       marker_o, feedback_o, full_o;
   logic [2:0] outstanding_o;
   logic [7:0] last_latency_o;
   logic       overflow_o, underflow_o, timeout_o;

   int checks = 0;
   int errors = 0;

   delay_marker_generator_if bus ();

   delay_marker_generator #(
      .MAX_OUTSTANDING (MAXO),
      .LAT_WIDTH       (8),
      .TIMEOUT_CYCLES  (TIMEOUT)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .bus_i          (bus),
      .clear_i        (clear_i),
      .marker_o       (marker_o),
      .feedback_o     (feedback_o),
      .outstanding_o  (outstanding_o),
      .full_o         (full_o),
      .last_latency_o (last_latency_o),
      .overflow_o     (overflow_o),
      .underflow_o    (underflow_o),
      .timeout_o      (timeout_o)
   );

   always #5 clk = ~clk;

   // Reference model state
   logic [7:0] m_ts;
   int         m_cnt;
   logic [7:0] m_fifo[$];
   logic [7:0] exp_lat_q[$];
   logic       m_marker, m_fb, m_ovf, m_unf, m_tmo;
   logic [7:0] m_last;
   logic       m_acc, m_ret, m_tmo_set;
   logic [7:0] m_head, m_diff;

   initial begin
      m_ts = 0; m_cnt = 0; m_marker = 0; m_fb = 0;
      m_ovf = 0; m_unf = 0; m_tmo = 0; m_last = 0;
   end

   always @(posedge clk) begin
      if (rst) begin
         m_ts = 0; m_cnt = 0; m_marker = 0; m_fb = 0;
         m_ovf = 0; m_unf = 0; m_tmo = 0; m_last = 0;
         m_fifo.delete();
         exp_lat_q.delete();
      end else begin
         m_ret = bus.rvalid && (m_fifo.size() > 0);
         m_acc = bus.req && bus.gnt && ((m_fifo.size() < MAXO) || m_ret);
         m_tmo_set = 1'b0;
         if (m_fifo.size() > 0) begin
            m_head = m_fifo[0];
            m_diff = m_ts - m_head;
            m_tmo_set = (m_diff == 8'(TIMEOUT));
         end
         m_ovf = (m_ovf && !clear_i) || (bus.req && bus.gnt && !m_acc);
         m_unf = (m_unf && !clear_i) || (bus.rvalid && (m_fifo.size() == 0));
         m_tmo = (m_tmo && !clear_i) || m_tmo_set;
         if (m_ret) begin
            m_head = m_fifo.pop_front();
            m_diff = m_ts - m_head;
            m_last = m_diff;
            exp_lat_q.push_back(m_diff);
         end
         if (m_acc) m_fifo.push_back(m_ts);
         m_cnt    = m_fifo.size();
         m_marker = m_acc;
         m_fb     = m_ret;
         m_ts     = m_ts + 8'd1;
      end
   end

   // Advance one cycle, then compare every output against the model and
   // pop the scoreboard whenever a feedback pulse appears.
   task automatic tick();
      logic [7:0] exp_lat;
      @(posedge clk); #1;
      checks++;
      if (marker_o !== m_marker) begin
         errors++; $display("FAIL marker: got %b expected %b at %0t", marker_o, m_marker, $time);
      end
      checks++;
      if (feedback_o !== m_fb) begin
         errors++; $display("FAIL feedback: got %b expected %b at %0t", feedback_o, m_fb, $time);
      end
      checks++;
      if (outstanding_o !== 3'(m_cnt) || full_o !== (m_cnt == MAXO)) begin
         errors++; $display("FAIL count: got %0d/full %b expected %0d at %0t", outstanding_o, full_o, m_cnt, $time);
      end
      checks++;
      if ({overflow_o, underflow_o, timeout_o} !== {m_ovf, m_unf, m_tmo}) begin
         errors++; $display("FAIL flags: got %b%b%b expected %b%b%b at %0t",
                            overflow_o, underflow_o, timeout_o, m_ovf, m_unf, m_tmo, $time);
      end
      checks++;
      if (last_latency_o !== m_last) begin
         errors++; $display("FAIL last_latency: got %0d expected %0d at %0t", last_latency_o, m_last, $time);
      end
      if (feedback_o === 1'b1) begin
         checks++;
         if (exp_lat_q.size() == 0) begin
            errors++; $display("FAIL scoreboard: feedback with no expected latency at %0t", $time);
         end else begin
            exp_lat = exp_lat_q.pop_front();
            if (last_latency_o !== exp_lat) begin
               errors++; $display("FAIL scoreboard latency: got %0d expected %0d", last_latency_o, exp_lat);
            end
         end
      end
   endtask

   task automatic drive(input logic r, input logic g, input logic v, input logic c);
      bus.req = r; bus.gnt = g; bus.rvalid = v; clear_i = c;
   endtask

   task automatic test_reset();
      rst = 1'b1; drive(1, 1, 1, 0);
      repeat (3) tick();
      checks++;
      if ({marker_o, feedback_o, outstanding_o, full_o, last_latency_o, overflow_o, underflow_o, timeout_o} !== '0) begin
         errors++; $display("FAIL reset_state: outputs not all zero (outstanding %0d lat %0d)", outstanding_o, last_latency_o);
      end
      drive(0, 0, 0, 0);
      rst = 1'b0;
      tick();
   endtask

   task automatic test_single();
      drive(1, 1, 0, 0); tick();
      checks++;
      if (marker_o !== 1'b1 || outstanding_o !== 3'd1) begin
         errors++; $display("FAIL single_accept: marker %b outstanding %0d expected 1/1", marker_o, outstanding_o);
      end
      drive(0, 0, 0, 0); tick(); tick();
      drive(0, 0, 1, 0); tick();
      checks++;
      if (feedback_o !== 1'b1 || last_latency_o !== 8'd3 || outstanding_o !== 3'd0 || full_o !== 1'b0) begin
         errors++; $display("FAIL single_retire: fb %b lat %0d outstanding %0d expected 1/3/0", feedback_o, last_latency_o, outstanding_o);
      end
      drive(0, 0, 0, 0); tick();
   endtask

   task automatic test_fill();
      drive(1, 1, 0, 0);
      repeat (5) tick();
      checks++;
      if (outstanding_o !== 3'd4 || full_o !== 1'b1 || marker_o !== 1'b0 || overflow_o !== 1'b1) begin
         errors++; $display("FAIL fill: outstanding %0d full %b marker %b overflow %b expected 4/1/0/1",
                            outstanding_o, full_o, marker_o, overflow_o);
      end
      drive(0, 0, 0, 1); tick();
      checks++;
      if (overflow_o !== 1'b0) begin
         errors++; $display("FAIL clear_overflow: got %b expected 0", overflow_o);
      end
      drive(0, 0, 0, 0); tick();
   endtask

   task automatic test_back_to_back();
      drive(1, 1, 1, 0); tick();
      checks++;
      if (outstanding_o !== 3'd4 || marker_o !== 1'b1 || feedback_o !== 1'b1 || overflow_o !== 1'b0) begin
         errors++; $display("FAIL full_push_pop: outstanding %0d marker %b fb %b ovf %b expected 4/1/1/0",
                            outstanding_o, marker_o, feedback_o, overflow_o);
      end
      drive(0, 0, 1, 0);
      repeat (4) tick();
      checks++;
      if (outstanding_o !== 3'd0 || full_o !== 1'b0) begin
         errors++; $display("FAIL drain: outstanding %0d full %b expected 0/0", outstanding_o, full_o);
      end
      drive(0, 0, 0, 0); tick();
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 300 && m_ts != 8'd250; i++) tick();
      drive(1, 1, 0, 0); tick();
      drive(0, 0, 0, 0);
      for (int i = 0; i < 300 && m_ts != 8'd5; i++) tick();
      drive(0, 0, 1, 0); tick();
      checks++;
      if (last_latency_o !== 8'd11) begin
         errors++; $display("FAIL wrap_latency: got %0d expected 11", last_latency_o);
      end
      drive(0, 0, 0, 0); tick();
   endtask

   task automatic test_underflow_timeout();
      drive(0, 0, 1, 0); tick();
      checks++;
      if (underflow_o !== 1'b1 || feedback_o !== 1'b0) begin
         errors++; $display("FAIL underflow: unf %b fb %b expected 1/0", underflow_o, feedback_o);
      end
      drive(0, 0, 0, 1); tick();
      checks++;
      if (underflow_o !== 1'b0) begin
         errors++; $display("FAIL clear_underflow: got %b expected 0", underflow_o);
      end
      drive(1, 1, 0, 0); tick();
      drive(0, 0, 0, 0);
      repeat (199) tick();
      checks++;
      if (timeout_o !== 1'b0) begin
         errors++; $display("FAIL timeout_early: got %b expected 0", timeout_o);
      end
      tick();
      checks++;
      if (timeout_o !== 1'b1) begin
         errors++; $display("FAIL timeout: got %b expected 1", timeout_o);
      end
      drive(0, 0, 1, 1); tick();
      drive(0, 0, 0, 1); tick();
      checks++;
      if (timeout_o !== 1'b0 || outstanding_o !== 3'd0) begin
         errors++; $display("FAIL timeout_clear: tmo %b outstanding %0d expected 0/0", timeout_o, outstanding_o);
      end
      drive(0, 0, 0, 0); tick();
   endtask

   task automatic test_reset_mid();
      drive(1, 1, 0, 0);
      repeat (3) tick();
      checks++;
      if (outstanding_o !== 3'd3) begin
         errors++; $display("FAIL pre_reset_count: got %0d expected 3", outstanding_o);
      end
      drive(0, 0, 0, 0);
      rst = 1'b1; tick();
      checks++;
      if ({marker_o, feedback_o, outstanding_o, full_o, last_latency_o, overflow_o, underflow_o, timeout_o} !== '0) begin
         errors++; $display("FAIL mid_reset: outputs not zero (outstanding %0d marker %b)", outstanding_o, marker_o);
      end
      rst = 1'b0;
      drive(0, 0, 1, 0); tick();
      checks++;
      if (underflow_o !== 1'b1 || feedback_o !== 1'b0) begin
         errors++; $display("FAIL post_reset_underflow: unf %b fb %b expected 1/0", underflow_o, feedback_o);
      end
      drive(0, 0, 0, 0); tick();
   endtask

   initial begin
      rst = 1'b1;
      drive(0, 0, 0, 0);
      test_reset();
      test_single();
      test_fill();
      test_back_to_back();
      test_wrap();
      test_underflow_timeout();
      test_reset_mid();
      checks++;
      if (exp_lat_q.size() != 0) begin
         errors++; $display("FAIL scoreboard_leftover: %0d latencies never observed", exp_lat_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
